// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and serial line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle level.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic synced
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= IDLE_LEVEL;
      synced <= IDLE_LEVEL;
    end else begin
      meta   <= line;
      synced <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: mid-bit sampling of 8E1 frames, parity/stop checks,
// and valid/ready delivery with error and overrun flags.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_in,
  input  logic       RX_ready,
  output logic [7:0] RX_data,
  output logic       RX_valid,
  output logic       RX_parity_err,
  output logic       RX_frame_err,
  output logic       RX_overrun,
  output logic       RX_busy
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_t     state;
  logic          rx_s;
  logic [CW-1:0] cyc_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          parity_bad;

  uart_rx_sync u_sync (
    .clk    (CLK),
    .rst_n  (RST),
    .line   (RX_in),
    .synced (rx_s)
  );

  // The handshake clear comes first so a frame completing in the same cycle
  // as an accept can overwrite the held byte.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= IDLE;
      cyc_cnt       <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      parity_bad    <= 1'b0;
      RX_data       <= 8'h00;
      RX_valid      <= 1'b0;
      RX_parity_err <= 1'b0;
      RX_frame_err  <= 1'b0;
      RX_overrun    <= 1'b0;
      RX_busy       <= 1'b0;
    end else begin
      if (RX_valid && RX_ready) begin
        RX_valid   <= 1'b0;
        RX_overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          cyc_cnt <= '0;
          if (rx_s == START_LEVEL) begin
            state   <= START;
            RX_busy <= 1'b1;
          end
        end

        START: begin
          if (cyc_cnt == HALF_END) begin
            cyc_cnt <= '0;
            bit_cnt <= '0;
            if (rx_s == START_LEVEL) begin
              state <= DATA;
            end else begin
              state   <= IDLE;
              RX_busy <= 1'b0;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        DATA: begin
          if (cyc_cnt == FULL_END) begin
            cyc_cnt        <= '0;
            shift[bit_cnt] <= rx_s;
            if (bit_cnt == LAST_BIT) begin
              state <= PARITY;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        PARITY: begin
          if (cyc_cnt == FULL_END) begin
            cyc_cnt    <= '0;
            parity_bad <= ^{shift, rx_s};
            state      <= STOP;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        STOP: begin
          if (cyc_cnt == FULL_END) begin
            cyc_cnt <= '0;
            if (!RX_valid || RX_ready) begin
              RX_data       <= shift;
              RX_parity_err <= parity_bad;
              RX_frame_err  <= (rx_s != STOP_LEVEL);
              RX_valid      <= 1'b1;
            end else begin
              RX_overrun <= 1'b1;
            end
            if (rx_s == STOP_LEVEL) begin
              state   <= IDLE;
              RX_busy <= 1'b0;
            end else begin
              state <= BREAK;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        // Only a return to the idle level re-arms start detection.
        BREAK: begin
          cyc_cnt <= '0;
          if (rx_s == IDLE_LEVEL) begin
            state   <= IDLE;
            RX_busy <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          RX_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus randomized
// frames compared against a frame-level reference model.
module tb_uart_receiver;

  localparam int N = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_in = 1'b1;
  logic       RX_ready = 1'b0;
  logic [7:0] RX_data;
  logic       RX_valid;
  logic       RX_parity_err;
  logic       RX_frame_err;
  logic       RX_overrun;
  logic       RX_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Observations gathered by the monitor: {parity_err, frame_err, data} and rise cycle.
  logic [9:0] obs_q[$];
  int         rise_q[$];
  logic       prev_valid   = 1'b0;
  int         valid_cycles = 0;
  int         busy_count   = 0;

  uart_receiver #(.CLKS_PER_BIT(N)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .RX_in         (RX_in),
    .RX_ready      (RX_ready),
    .RX_data       (RX_data),
    .RX_valid      (RX_valid),
    .RX_parity_err (RX_parity_err),
    .RX_frame_err  (RX_frame_err),
    .RX_overrun    (RX_overrun),
    .RX_busy       (RX_busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    prev_valid <= RX_valid;
    if (RX_valid && !prev_valid) begin
      obs_q.push_back({RX_parity_err, RX_frame_err, RX_data});
      rise_q.push_back(cyc);
    end
    if (RX_valid) valid_cycles <= valid_cycles + 1;
    if (RX_busy) busy_count <= busy_count + 1;
  end

  // Expected delivery of a frame: parity error when the count of ones over
  // data plus parity bit is odd, frame error when the stop bit is not 1.
  function automatic logic [9:0] model_frame(input logic [7:0] d, input logic p, input logic stop);
    int ones;
    ones = (p == 1'b1) ? 1 : 0;
    for (int i = 0; i < 8; i++) if (d[i] == 1'b1) ones++;
    return {((ones % 2) == 1), (stop != 1'b1), d};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, output int start_cyc);
    logic [10:0] bits;
    bits = {stop, p, d, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < 11; i++) begin
      RX_in = bits[i];
      step(N);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    RX_in = 1'b1;
    RX_ready = 1'b0;
    step(3);
    n_checks++; if (RX_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_data got=%h exp=00", RX_data); end
    n_checks++; if (RX_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid got=%b exp=0", RX_valid); end
    n_checks++; if (RX_parity_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_parity got=%b exp=0", RX_parity_err); end
    n_checks++; if (RX_frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_frame got=%b exp=0", RX_frame_err); end
    n_checks++; if (RX_overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overrun got=%b exp=0", RX_overrun); end
    n_checks++; if (RX_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got=%b exp=0", RX_busy); end
    RST = 1'b1;
    step(4);
  endtask

  task automatic test_basic();
    int base, vbase, s;
    logic [9:0] got;
    int rise;
    RX_ready = 1'b1;
    base = obs_q.size();
    vbase = valid_cycles;
    send_frame(8'hA5, 1'b0, 1'b1, s);
    step(8);
    got  = (obs_q.size() > base) ? obs_q[base] : 'x;
    rise = (rise_q.size() > base) ? rise_q[base] : -1;
    n_checks++; if (obs_q.size() !== base + 1) begin n_fail++; $display("[TB] FAIL basic_count got=%0d exp=%0d", obs_q.size() - base, 1); end
    n_checks++; if (got !== model_frame(8'hA5, 1'b0, 1'b1)) begin n_fail++; $display("[TB] FAIL basic_frame got=%h exp=%h", got, model_frame(8'hA5, 1'b0, 1'b1)); end
    n_checks++; if (rise !== s + 3 + N/2 + 10*N) begin n_fail++; $display("[TB] FAIL basic_latency got=%0d exp=%0d", rise - s, 3 + N/2 + 10*N); end
    n_checks++; if (valid_cycles - vbase !== 1) begin n_fail++; $display("[TB] FAIL basic_valid_len got=%0d exp=1", valid_cycles - vbase); end
    n_checks++; if (RX_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_busy got=%b exp=0", RX_busy); end
  endtask

  task automatic test_parity_error();
    int base, s;
    logic [9:0] got;
    base = obs_q.size();
    send_frame(8'h01, 1'b0, 1'b1, s);
    step(8);
    got = (obs_q.size() > base) ? obs_q[base] : 'x;
    n_checks++; if (got !== model_frame(8'h01, 1'b0, 1'b1)) begin n_fail++; $display("[TB] FAIL parity_frame got=%h exp=%h", got, model_frame(8'h01, 1'b0, 1'b1)); end
    n_checks++; if (got[9] !== 1'b1) begin n_fail++; $display("[TB] FAIL parity_flag got=%b exp=1", got[9]); end
  endtask

  task automatic test_glitch();
    int base, bbase;
    base = obs_q.size();
    bbase = busy_count;
    RX_in = 1'b0;
    step(N/4);
    RX_in = 1'b1;
    step(2*N);
    n_checks++; if (!(busy_count > bbase)) begin n_fail++; $display("[TB] FAIL glitch_busy_pulse got=%0d exp>0", busy_count - bbase); end
    n_checks++; if (RX_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL glitch_busy_end got=%b exp=0", RX_busy); end
    n_checks++; if (obs_q.size() !== base) begin n_fail++; $display("[TB] FAIL glitch_no_valid got=%0d exp=0", obs_q.size() - base); end
  endtask

  task automatic test_break();
    int base, s;
    logic [9:0] got;
    base = obs_q.size();
    send_frame(8'h3C, 1'b0, 1'b0, s);
    step(3*N);
    got = (obs_q.size() > base) ? obs_q[base] : 'x;
    n_checks++; if (got !== model_frame(8'h3C, 1'b0, 1'b0)) begin n_fail++; $display("[TB] FAIL break_frame got=%h exp=%h", got, model_frame(8'h3C, 1'b0, 1'b0)); end
    n_checks++; if (RX_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL break_busy_held got=%b exp=1", RX_busy); end
    RX_in = 1'b1;
    step(N);
    n_checks++; if (RX_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL break_busy_release got=%b exp=0", RX_busy); end
    n_checks++; if (obs_q.size() !== base + 1) begin n_fail++; $display("[TB] FAIL break_single got=%0d exp=1", obs_q.size() - base); end
    send_frame(8'hC3, 1'b0, 1'b1, s);
    step(8);
    got = (obs_q.size() > base + 1) ? obs_q[base + 1] : 'x;
    n_checks++; if (got !== model_frame(8'hC3, 1'b0, 1'b1)) begin n_fail++; $display("[TB] FAIL break_next got=%h exp=%h", got, model_frame(8'hC3, 1'b0, 1'b1)); end
  endtask

  task automatic test_back_to_back();
    int base, s;
    RX_ready = 1'b0;
    base = obs_q.size();
    send_frame(8'h11, 1'b0, 1'b1, s);
    send_frame(8'h22, 1'b0, 1'b1, s);
    step(8);
    n_checks++; if (RX_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_valid got=%b exp=1", RX_valid); end
    n_checks++; if (RX_data !== 8'h11) begin n_fail++; $display("[TB] FAIL b2b_data got=%h exp=11", RX_data); end
    n_checks++; if (RX_overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_overrun got=%b exp=1", RX_overrun); end
    n_checks++; if (obs_q.size() !== base + 1) begin n_fail++; $display("[TB] FAIL b2b_count got=%0d exp=1", obs_q.size() - base); end
    RX_ready = 1'b1;
    step(1);
    RX_ready = 1'b0;
    n_checks++; if (RX_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_accept_valid got=%b exp=0", RX_valid); end
    n_checks++; if (RX_overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_accept_overrun got=%b exp=0", RX_overrun); end
    step(4);
  endtask

  task automatic test_reset_midframe();
    int base, s;
    logic [7:0] d;
    logic [9:0] got;
    RX_ready = 1'b0;
    send_frame(8'h77, 1'b0, 1'b1, s);
    step(8);
    d = 8'h5A;
    RX_in = 1'b0;
    step(N);
    for (int i = 0; i < 4; i++) begin
      RX_in = d[i];
      step(N);
    end
    RX_in = d[4];
    step(N/2);
    RST = 1'b0;
    #1;
    n_checks++; if (RX_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_valid got=%b exp=0", RX_valid); end
    n_checks++; if (RX_data !== 8'h00) begin n_fail++; $display("[TB] FAIL midrst_data got=%h exp=00", RX_data); end
    n_checks++; if (RX_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_busy got=%b exp=0", RX_busy); end
    step(2);
    RST = 1'b1;
    RX_in = 1'b1;
    RX_ready = 1'b1;
    step(N);
    base = obs_q.size();
    send_frame(8'h5A, 1'b0, 1'b1, s);
    step(8);
    got = (obs_q.size() > base) ? obs_q[base] : 'x;
    n_checks++; if (got !== model_frame(8'h5A, 1'b0, 1'b1)) begin n_fail++; $display("[TB] FAIL midrst_next got=%h exp=%h", got, model_frame(8'h5A, 1'b0, 1'b1)); end
  endtask

  task automatic test_random();
    int base, s;
    logic [7:0] d;
    logic p, stop;
    logic [9:0] got;
    RX_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      d    = 8'($urandom_range(0, 255));
      p    = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 3) != 0);
      base = obs_q.size();
      send_frame(d, p, stop, s);
      RX_in = 1'b1;
      step(N);
      got = (obs_q.size() > base) ? obs_q[base] : 'x;
      n_checks++; if (got !== model_frame(d, p, stop)) begin n_fail++; $display("[TB] FAIL random_%0d got=%h exp=%h", k, got, model_frame(d, p, stop)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_error();
    test_glitch();
    test_break();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout exp=completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel receive stage that consumes the single-line frame produced by the UART transmit path: start bit (0), 8 data bits LSB first, even-parity bit, stop bit (1). It synchronises the asynchronous line, samples every bit at its midpoint, and checks parity and stop. It then presents the byte on a valid/ready handshake with per-byte error flags. It sits at the far end of the serial link and feeds the receive-side consumer logic.

## Interface
- CLKS_PER_BIT, 16: CLK cycles per serial bit; even, ≥ 4.
- CLK  in  1  sole clock; all state on rising edge.
- RST  in  1  reset, asynchronous, active-low.
- RX_in  in  1  serial line, asynchronous to CLK, idle high.
- RX_ready  in  1  consumer accepts the held byte this cycle.
- RX_data  out  8  received byte.
- RX_valid  out  1  RX_data and flags are held and valid.
- RX_parity_err  out  1  held byte failed the even-parity check.
- RX_frame_err  out  1  held byte had stop bit = 0.
- RX_overrun  out  1  at least one frame was dropped while RX_valid was high.
- RX_busy  out  1  frame reception in progress (state ≠ IDLE).

## Operation
- RX_in passes through a 2-flop synchroniser. All logic uses the synchronised value rx_s, which resets to 1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- A bit counter (0..7) and a cycle counter (0..CLKS_PER_BIT-1) control sampling.
- IDLE: when rx_s = 0, go to START and clear the cycle counter.
- START: after CLKS_PER_BIT/2 cycles, re-sample rx_s.
  - rx_s = 1: false start, return to IDLE. No flags change.
  - rx_s = 0: go to DATA with the bit counter at 0.
- DATA: every CLKS_PER_BIT cycles, shift rx_s into bit[bit counter] (LSB first). After bit 7, go to PARITY.
- PARITY: sample one bit p. parity_bad = XOR(data[7:0], p) ≠ 0.
- STOP: sample the stop bit, then complete the frame (delivery rules below).
  - Stop = 1: go to IDLE on the same edge. The next start bit may begin half a bit later, so back-to-back frames are supported.
  - Stop = 0: set the frame error and go to BREAK.
- BREAK: wait until rx_s = 1, then go to IDLE. A line held low never produces repeated frames.
- Delivery when a frame completes:
  - RX_valid = 0, or RX_ready = 1 in the same cycle: load RX_data, RX_parity_err and RX_frame_err; RX_valid = 1.
  - RX_valid = 1 and RX_ready = 0: discard the new frame. RX_data and its flags are unchanged; set RX_overrun.
- Handshake: RX_valid holds until a cycle with RX_ready = 1; on the next edge RX_valid = 0. RX_ready while RX_valid = 0 is ignored.
- RX_overrun stays set until the next accepted handshake.
- Frames with errors are still delivered, with their flags set.

## Timing
- Reset (RST low, any state, mid-frame included):
  - FSM to IDLE, counters 0, synchroniser flops 1.
  - RX_data = 8'h00; RX_valid, RX_parity_err, RX_frame_err, RX_overrun, RX_busy = 0.
  - Any partial frame is lost.
- Synchroniser latency: 2 cycles from an RX_in edge to rx_s.
- The start edge is seen at rx_s cycle T0. Sample points are T0 + CLKS_PER_BIT/2 + k·CLKS_PER_BIT:
  - k = 0: start bit.
  - k = 1..8: data bits 0..7.
  - k = 9: parity.
  - k = 10: stop.
- RX_valid rises on the edge after the stop-bit sample.
- RX_busy goes high the cycle after the start edge. It goes low on the same edge RX_valid rises, or stays high through BREAK.
- Counters never wrap mid-bit. The cycle counter reloads to 0 at each sample point.

## Structure
- Package uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP, BREAK).
  - Constants: DATA_BITS = 8, IDLE_LEVEL = 1'b1, START_LEVEL = 1'b0, STOP_LEVEL = 1'b1.
  - Shared by the transmit path.
- One sub-module: uart_rx_sync, the 2-flop synchroniser with asynchronous active-low reset to 1.
- Shift register, parity check and FSM stay in uart_receiver.

## Test plan
- Byte 8'hA5 with correct parity (p = 0), stop = 1, RX_ready held high:
  - RX_data = 8'hA5, RX_valid for one cycle, all error flags 0.
  - RX_valid rises exactly 1 cycle after the stop sample.
- Byte 8'h01 sent with p = 0 (correct is 1): RX_data = 8'h01, RX_parity_err = 1.
- Low glitch of CLKS_PER_BIT/4 cycles on an idle line: no RX_valid. RX_busy pulses and then returns to 0.
- Byte 8'h3C with stop = 0, then line held low for 3 bit times:
  - RX_frame_err = 1, one delivery only.
  - Receiver stays in BREAK until the line goes high; the next frame 8'hC3 is received cleanly.
- Two back-to-back frames 8'h11 then 8'h22, RX_ready = 0 throughout:
  - RX_data stays 8'h11, RX_overrun = 1.
  - After RX_ready = 1 for one cycle: RX_valid = 0, RX_overrun = 0.
- RST asserted during data bit 4 of a frame:
  - All outputs at their reset values immediately (asynchronous).
  - After release, a following frame 8'h5A is received correctly.
